// File: rtl/tick_burst_gen.sv
// tick_burst_gen: programmable enable-pulse source for pulse-counting timers.
// A start in IDLE latches the period P (0 is treated as 1), the count N and the
// cont flag. The block then emits N single-cycle ticks P clocks apart and pulses
// done. In continuous mode it ticks every P clocks until stop or reset.
// Ports:
//   clk, r_n      clock (rising edge), asynchronous active-low reset
//   start, stop   burst request (IDLE only), abort (RUN only)
//   cont          1 = continuous prescaler mode, count ignored
//   period, count tick spacing and number of ticks, latched at start
//   tick          one-cycle enable pulse
//   busy          high while in RUN
//   done          one-cycle pulse after the last tick of a burst
//   left          ticks still to emit (0 in continuous mode and IDLE)
module tick_burst_gen #(
  parameter int unsigned PERIOD_BITS = 8,
  parameter int unsigned COUNT_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   r_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cont,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [COUNT_BITS-1:0]  count,
  output logic                   tick,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_BITS-1:0]  left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PERIOD_BITS-1:0] div_q, div_d;
  logic [PERIOD_BITS-1:0] pm1_q, pm1_d;   // latched max(period,1)-1
  logic [COUNT_BITS-1:0]  left_q, left_d;
  logic                   cont_q, cont_d;
  logic                   tick_q, tick_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [PERIOD_BITS-1:0] start_pm1;
  logic                   start_wrap;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pm1_d   = pm1_q;
    left_d  = left_q;
    cont_d  = cont_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    start_pm1  = (period == '0) ? '0 : period - PERIOD_BITS'(1);
    // The start edge is the divider's first step (count 0), so P=1 ticks at once.
    start_wrap = (start_pm1 == '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pm1_d  = start_pm1;
          cont_d = cont;
          if (cont || (count != '0)) begin
            state_d = RUN;
            div_d   = start_wrap ? '0 : PERIOD_BITS'(1);
            tick_d  = start_wrap;
            left_d  = cont ? '0 : count - COUNT_BITS'(start_wrap);
          end else begin
            state_d = FIN;
            div_d   = '0;
            left_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          // Abort wins over a due tick; no done pulse.
          state_d = IDLE;
          div_d   = '0;
          left_d  = '0;
        end else if (!cont_q && (left_q == '0)) begin
          // Last tick was emitted in the previous cycle.
          state_d = FIN;
          div_d   = '0;
          done_d  = 1'b1;
        end else if (div_q == pm1_q) begin
          div_d  = '0;
          tick_d = 1'b1;
          if (!cont_q) begin
            left_d = left_q - COUNT_BITS'(1);
          end
        end else begin
          div_d = div_q + PERIOD_BITS'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        left_d  = '0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      pm1_q   <= '0;
      left_q  <= '0;
      cont_q  <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pm1_q   <= pm1_d;
      left_q  <= left_d;
      cont_q  <= cont_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;
  assign left = left_q;

endmodule
